// File: rtl/jtopl_timer_regs.sv
// CPU register front end for the OPL timer pair: bus decode, timer registers,
// status byte / IRQ generation, write-busy window and forwarding of other writes.
module jtopl_timer_regs #(
  parameter int unsigned ADDR_WAIT = 4,
  parameter int unsigned DATA_WAIT = 24,
  parameter int unsigned BW        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       irq_n,
  output logic       csm,
  output logic       nts,
  output logic       busy,
  output logic [7:0] up_addr,
  output logic [7:0] up_data,
  output logic       up_wr
);

  logic          wr_act;
  logic          wr_l;
  logic          wr_ev;
  logic [7:0]    addr_l;
  logic          mask_A;
  logic          mask_B;
  logic          fa;
  logic          fb;
  logic          irq;
  logic [BW-1:0] cnt;
  logic [BW-1:0] cnt_nx;

  assign wr_act = ~cs_n & ~wr_n;
  assign wr_ev  = wr_act & ~wr_l;

  // Mask acts combinationally so unmasking a still-set flag shows it again.
  assign fa  = flag_A & ~mask_A;
  assign fb  = flag_B & ~mask_B;
  assign irq = fa | fb;

  // A new write reloads the window and wins over the cen decrement.
  always_comb begin
    cnt_nx = cnt;
    if (wr_ev) begin
      cnt_nx = addr ? BW'(DATA_WAIT) : BW'(ADDR_WAIT);
    end else if (cen && cnt != '0) begin
      cnt_nx = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // Tracked through reset so a strobe held across release yields no event.
    wr_l <= wr_act;
    if (rst) begin
      value_A    <= 8'd0;
      value_B    <= 8'd0;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      mask_A     <= 1'b0;
      mask_B     <= 1'b0;
      csm        <= 1'b0;
      nts        <= 1'b0;
      addr_l     <= 8'd0;
      up_addr    <= 8'd0;
      up_data    <= 8'd0;
      up_wr      <= 1'b0;
      dout       <= 8'd0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      irq_n      <= 1'b1;
      busy       <= 1'b0;
      cnt        <= '0;
    end else begin
      up_wr      <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      dout       <= {irq, fa, fb, 5'b0};
      irq_n      <= ~irq;
      cnt        <= cnt_nx;
      busy       <= (cnt_nx != '0);
      if (wr_ev && !addr) begin
        addr_l <= din;
      end
      if (wr_ev && addr) begin
        case (addr_l)
          8'h02: value_A <= din;
          8'h03: value_B <= din;
          8'h04: begin
            if (din[7]) begin
              clr_flag_A <= 1'b1;
              clr_flag_B <= 1'b1;
            end else begin
              load_A     <= din[0];
              load_B     <= din[1];
              mask_A     <= din[6];
              mask_B     <= din[5];
              clr_flag_A <= din[6];
              clr_flag_B <= din[5];
            end
          end
          8'h08: begin
            csm <= din[7];
            nts <= din[6];
          end
          default: begin
            up_addr <= addr_l;
            up_data <= din;
            up_wr   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtopl_timer_regs.sv
// Directed bench for jtopl_timer_regs with immediate-assertion checks.
module tb_jtopl_timer_regs;

  logic       clk = 1'b0;
  logic       rst, cen, cs_n, wr_n, addr;
  logic [7:0] din, dout;
  logic       flag_A, flag_B;
  logic [7:0] value_A, value_B, up_addr, up_data;
  logic       load_A, load_B, clr_flag_A, clr_flag_B, irq_n, csm, nts, busy, up_wr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtopl_timer_regs dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .cs_n       (cs_n),
    .wr_n       (wr_n),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .flag_A     (flag_A),
    .flag_B     (flag_B),
    .value_A    (value_A),
    .value_B    (value_B),
    .load_A     (load_A),
    .load_B     (load_B),
    .clr_flag_A (clr_flag_A),
    .clr_flag_B (clr_flag_B),
    .irq_n      (irq_n),
    .csm        (csm),
    .nts        (nts),
    .busy       (busy),
    .up_addr    (up_addr),
    .up_data    (up_data),
    .up_wr      (up_wr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Release the strobe for a cycle, then assert it; returns just after the event edge.
  task automatic wr(input logic a, input logic [7:0] d);
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();
    cs_n = 1'b0;
    wr_n = 1'b0;
    addr = a;
    din  = d;
    tick();
  endtask

  task automatic wait_idle;
    int n;
    n    = 0;
    cs_n = 1'b1;
    wr_n = 1'b1;
    cen  = 1'b1;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int lows;
    int pulses;
    logic upw_seen;

    rst = 1'b1; cen = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 1'b0; din = 8'h00;
    flag_A = 1'b0; flag_B = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_value_A", {24'd0, value_A}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_irq_n", {31'd0, irq_n}, 32'd1);
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_up_wr", {31'd0, up_wr}, 32'd0);

    // Reg 0x02 write and busy length counted in cen pulses
    wr(1'b0, 8'h02);
    check("addr_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    wr(1'b1, 8'hA5);
    check("value_A", {24'd0, value_A}, 32'hA5);
    check("busy_start", {31'd0, busy}, 32'd1);
    cs_n = 1'b1; wr_n = 1'b1;
    n = 0;
    upw_seen = up_wr;
    for (int i = 0; i < 200; i++) begin
      cen = i[0];
      tick();
      upw_seen |= up_wr;
      if (cen) n++;
      if (!busy) break;
    end
    check("busy_cen_pulses", n, 32'd24);
    check("timer_no_up_wr", {31'd0, upw_seen}, 32'd0);

    // Reg 0x04 load bits, then flag reset bit
    wr(1'b0, 8'h04);
    wait_idle();
    wr(1'b1, 8'h03);
    check("load_A", {31'd0, load_A}, 32'd1);
    check("load_B", {31'd0, load_B}, 32'd1);
    check("no_clr", {30'd0, clr_flag_A, clr_flag_B}, 32'd0);
    wr(1'b1, 8'h80);
    check("clr_pulse", {30'd0, clr_flag_A, clr_flag_B}, 32'd3);
    check("load_kept", {30'd0, load_A, load_B}, 32'd3);
    tick();
    check("clr_one_cycle", {30'd0, clr_flag_A, clr_flag_B}, 32'd0);

    // Status byte, IRQ and masking
    flag_A = 1'b1;
    tick();
    tick();
    check("dout_fa", {24'd0, dout}, 32'hC0);
    check("irq_low", {31'd0, irq_n}, 32'd0);
    wr(1'b1, 8'h41);
    check("mask_clr", {30'd0, clr_flag_A, clr_flag_B}, 32'd2);
    tick();
    check("dout_masked", {24'd0, dout}, 32'h00);
    check("irq_masked", {31'd0, irq_n}, 32'd1);
    wr(1'b1, 8'h01);
    tick();
    check("dout_unmask", {24'd0, dout}, 32'hC0);
    flag_A = 1'b0;
    flag_B = 1'b1;
    tick();
    tick();
    check("dout_fb", {24'd0, dout}, 32'hA0);
    flag_B = 1'b0;

    // Forwarded write with a long strobe
    wr(1'b0, 8'h20);
    wait_idle();
    wr(1'b1, 8'h7F);
    check("up_wr", {31'd0, up_wr}, 32'd1);
    check("up_addr", {24'd0, up_addr}, 32'h20);
    check("up_data", {24'd0, up_data}, 32'h7F);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (up_wr) pulses++;
    end
    check("single_up_wr", pulses, 32'd0);

    // Reload at counter 3, busy must not drop
    wait_idle();
    wr(1'b1, 8'h55);
    cs_n = 1'b1; wr_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!busy) lows++;
    end
    wr(1'b1, 8'h56);
    cs_n = 1'b1; wr_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      tick();
      if (!busy) lows++;
    end
    check("busy_continuous", lows, 32'd0);

    // Reset mid-busy, with a strobe held across reset release
    wr(1'b1, 8'h57);
    check("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    din = 8'h33;
    tick();
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_regs", {value_A, value_B, up_addr, 6'd0, load_A, load_B}, 32'h0);
    check("rst_up_data", {24'd0, up_data}, 32'h00);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("held_strobe_no_ev", {30'd0, up_wr, busy}, 32'd0);

    // Reg 0x08
    wr(1'b0, 8'h08);
    wait_idle();
    wr(1'b1, 8'hC0);
    check("csm_nts_set", {29'd0, csm, nts, up_wr}, 32'd6);
    wr(1'b1, 8'h00);
    check("csm_nts_clr", {29'd0, csm, nts, up_wr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jtopl_timer_regs.md
Name: jtopl_timer_regs

Overview:
- CPU-side register front end for the OPL timer pair.
- Decodes the two-port bus (address/data) and holds the timer registers 0x02, 0x03, 0x04 and 0x08.
- Drives the timer block's value, load and flag-clear inputs, and builds the masked status byte and IRQ.
- Generates the write-busy window and forwards all other register writes to the operator/channel register file.

Parameters:
- ADDR_WAIT, 4: cen cycles busy stays high after an address-port write.
- DATA_WAIT, 24: cen cycles busy stays high after a data-port write.
- BW, 5: busy counter width; must satisfy 2^BW > max(ADDR_WAIT, DATA_WAIT).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cen  in  1  clock enable for the busy counter.
- cs_n  in  1  chip select, active low.
- wr_n  in  1  write strobe, active low.
- addr  in  1  0 = address port, 1 = data port.
- din  in  8  CPU write data.
- dout  out  8  registered status byte.
- flag_A  in  1  timer A flag, from the timer block.
- flag_B  in  1  timer B flag, from the timer block.
- value_A  out  8  reg 0x02.
- value_B  out  8  reg 0x03.
- load_A  out  1  reg 0x04 bit0.
- load_B  out  1  reg 0x04 bit1.
- clr_flag_A  out  1  one-cycle flag-clear pulse, timer A.
- clr_flag_B  out  1  one-cycle flag-clear pulse, timer B.
- irq_n  out  1  active-low interrupt.
- csm  out  1  reg 0x08 bit7.
- nts  out  1  reg 0x08 bit6.
- busy  out  1  write-busy indication.
- up_addr  out  8  forwarded register address.
- up_data  out  8  forwarded register data.
- up_wr  out  1  one-cycle forward strobe.

Behaviour:
- Reset, synchronous on clk while rst=1:
  - value_A, value_B, load_A, load_B, mask_A, mask_B, csm, nts, latched address, up_addr, up_data, dout all 0.
  - up_wr, clr_flag_A, clr_flag_B, busy all 0; irq_n=1; busy counter = 0.
  - Reset asserted mid-busy clears busy in the next cycle.
- Write detect:
  - wr_act = ~cs_n & ~wr_n, registered once into wr_l.
  - A write event is wr_act & ~wr_l: exactly one event per strobe, regardless of strobe length.
  - Strobe held across reset release produces no event.
- Address-port event (addr=0): latched address <= din; busy counter <= ADDR_WAIT.
- Data-port event (addr=1): busy counter <= DATA_WAIT; din is applied to the latched address, visible the next cycle:
  - 0x02: value_A <= din.
  - 0x03: value_B <= din.
  - 0x04, din[7]=1:
    - clr_flag_A=1 and clr_flag_B=1 for exactly one clk cycle.
    - load_A, load_B, mask_A, mask_B unchanged.
  - 0x04, din[7]=0:
    - load_A <= din[0], load_B <= din[1], mask_A <= din[6], mask_B <= din[5].
    - clr_flag_A pulses if din[6]=1; clr_flag_B pulses if din[5]=1.
  - 0x08: csm <= din[7], nts <= din[6].
  - Any other address: up_addr <= latched address, up_data <= din, up_wr=1 for one cycle.
  - Timer addresses never raise up_wr.
- Busy:
  - busy = (counter != 0), registered.
  - Counter decrements on cen while nonzero and saturates at 0.
  - Writes during busy are accepted; the counter reloads with the new WAIT value, so no write is dropped.
  - Reload has priority over a simultaneous cen decrement.
- Status and IRQ:
  - fa = flag_A & ~mask_A; fb = flag_B & ~mask_B; irq = fa | fb.
  - dout <= {irq, fa, fb, 5'b0} every cycle: 1-cycle latency, independent of cs_n/addr.
  - irq_n <= ~irq, registered.
  - Flag rising and a clr pulse in the same cycle: the timer block decides; this block only reflects its flag inputs.
- Mask change is combinational into fa/fb: a masked, still-set flag reappears when unmasked unless it was cleared by the mask write pulse.

Test Plan:
- Reset, then write addr 0x02 and data 0xA5 -> value_A=0xA5 one cycle after the data event; busy high for exactly 24 cen pulses; up_wr never asserted.
- Write 0x04 with data 0x03 -> load_A=1, load_B=1, no clr pulse. Then data 0x80 -> clr_flag_A and clr_flag_B high exactly one cycle; load_A and load_B still 1.
- flag_A=1, flag_B=0, masks 0 -> dout=0xC0, irq_n=0. Write 0x04 with data 0x41 -> mask_A=1, clr_flag_A pulses, dout=0x00, irq_n=1.
- Write address 0x20, then data 0x7F with wr_n held low 10 cycles -> single up_wr pulse, up_addr=0x20, up_data=0x7F.
- Second data write at busy counter=3 -> counter reloads to 24, busy stays continuously high; rst asserted mid-busy -> busy=0 next cycle, all registers zero.
- Write 0x08 with data 0xC0 -> csm=1, nts=1; then data 0x00 -> both 0, no up_wr on either write.
